regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with byte-lane writes and a pending scoreboard.
// Two write ports (port 1 wins per lane on collisions), two combinational read ports,
// and one pending bit per register. The pending bit is set by set_en and cleared by any write.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding
// for both the data and the busy flags.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W/8-1:0]   wbe0,
    input  logic                  wen1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [DATA_W/8-1:0]   wbe1,
    input  logic [ADDR_W-1:0]     raddr1,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    // Data writes and scoreboard sets to register 0 are dropped when it is hardwired.
    logic wr0_ok;
    logic wr1_ok;
    logic set_ok;

    assign wr0_ok = wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok = wen1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

    // Next-state for storage and scoreboard: port 1 applied after port 0 so it wins per lane; set after clear.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int b = 0; b < int'(NB); b++) begin
            if (wr0_ok && wbe0[b]) begin
                regs_d[waddr0][8*b +: 8] = wdata0[8*b +: 8];
            end
            if (wr1_ok && wbe1[b]) begin
                regs_d[waddr1][8*b +: 8] = wdata1[8*b +: 8];
            end
        end
        if (wen0) begin
            pend_d[waddr0] = 1'b0;
        end
        if (wen1) begin
            pend_d[waddr1] = 1'b0;
        end
        if (set_ok) begin
            pend_d[set_addr] = 1'b1;
        end
    end

    // State registers; reset overrides every write and set in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    logic [ADDR_W-1:0] raddr_w [2];

    assign raddr_w[0] = raddr1;
    assign raddr_w[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] rd_c;
        logic              busy_c;

        // Read mux: stored state, optionally overlaid with this cycle's writes; register 0 forced to zero.
        always_comb begin
            rd_c   = regs_q[raddr_w[p]];
            busy_c = pend_q[raddr_w[p]];
`ifdef REGFILE_BYPASS_EN
            if (!rst) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (wr1_ok && (waddr1 == raddr_w[p]) && wbe1[b]) begin
                        rd_c[8*b +: 8] = wdata1[8*b +: 8];
                    end else if (wr0_ok && (waddr0 == raddr_w[p]) && wbe0[b]) begin
                        rd_c[8*b +: 8] = wdata0[8*b +: 8];
                    end
                end
                if (((wen0 && (waddr0 == raddr_w[p])) || (wen1 && (waddr1 == raddr_w[p])))
                    && !(set_ok && (set_addr == raddr_w[p]))) begin
                    busy_c = 1'b0;
                end
            end
`endif
            if ((ZERO_REG != 0) && (raddr_w[p] == '0)) begin
                rd_c   = '0;
                busy_c = 1'b0;
            end
        end
    end

    assign rdata1 = g_rd[0].rd_c;
    assign rdata2 = g_rd[1].rd_c;
    assign busy1  = g_rd[0].busy_c;
    assign busy2  = g_rd[1].busy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed table, hand-written corner sequences, and random traffic
// checked against a byte-array reference model.
module tb_regfile_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NB     = 4;
    localparam int unsigned DEPTH  = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                wen0, wen1, set_en;
    logic [ADDR_W-1:0]   waddr0, waddr1, raddr1, raddr2, set_addr;
    logic [DATA_W-1:0]   wdata0, wdata1, rdata1, rdata2;
    logic [NB-1:0]       wbe0, wbe1;
    logic                busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_mem  [DEPTH][NB];
    bit         m_pend [DEPTH];

    typedef struct {
        logic              w0;
        logic [ADDR_W-1:0] a0;
        logic [31:0]       d0;
        logic [3:0]        be0;
        logic              w1;
        logic [ADDR_W-1:0] a1;
        logic [31:0]       d1;
        logic [3:0]        be1;
        logic              se;
        logic [ADDR_W-1:0] sa;
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
        logic [31:0]       e1;
        logic [31:0]       e2;
        logic              eb1;
        logic              eb2;
    } vec_t;

    vec_t tbl [7];

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0), .wbe0(wbe0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .wbe1(wbe1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .set_en(set_en), .set_addr(set_addr), .busy1(busy1), .busy2(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: stored value assembled from the byte array.
    function automatic logic [31:0] m_stored(input logic [ADDR_W-1:0] a);
        logic [31:0] v;
        for (int i = 0; i < int'(NB); i++) v[8*i +: 8] = m_mem[a][i];
        return v;
    endfunction

    // Reference: what a read port should show right now, given the current inputs.
    function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
        logic [31:0] v;
        v = m_stored(a);
`ifdef REGFILE_BYPASS_EN
        if (!rst && a != 0) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wen1 && waddr1 == a && wbe1[i]) v[8*i +: 8] = wdata1[8*i +: 8];
                else if (wen0 && waddr0 == a && wbe0[i]) v[8*i +: 8] = wdata0[8*i +: 8];
            end
        end
`endif
        return v;
    endfunction

    function automatic logic m_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (!rst && ((wen0 && waddr0 == a) || (wen1 && waddr1 == a)) && !(set_en && set_addr == a))
            b = 1'b0;
`endif
        return b;
    endfunction

    // Reference: effect of one rising edge on the model.
    task automatic model_edge();
        if (rst) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                for (int i = 0; i < int'(NB); i++) m_mem[a][i] = 8'h00;
                m_pend[a] = 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wen0 && wbe0[i] && waddr0 != 0) m_mem[waddr0][i] = wdata0[8*i +: 8];
                if (wen1 && wbe1[i] && waddr1 != 0) m_mem[waddr1][i] = wdata1[8*i +: 8];
            end
            if (wen0) m_pend[waddr0] = 1'b0;
            if (wen1) m_pend[waddr1] = 1'b0;
            if (set_en && set_addr != 0) m_pend[set_addr] = 1'b1;
        end
    endtask

    task automatic idle();
        rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0; set_en = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        wbe0 = '0; wbe1 = '0; set_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        idle();
        raddr1 = '0; raddr2 = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset sweep: every address reads zero and not busy.
        for (int a = 0; a < int'(DEPTH); a++) begin
            raddr1 = ADDR_W'(a);
            raddr2 = ADDR_W'(DEPTH - 1 - a);
            #1;
            chk("reset_rdata1", rdata1, 32'h0);
            chk("reset_rdata2", rdata2, 32'h0);
            chk("reset_busy1", 32'(busy1), 32'h0);
            chk("reset_busy2", 32'(busy2), 32'h0);
        end

        tbl[0] = '{1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0,
                   5'd5, 5'd0, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd5, 32'h11223344, 4'h5, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0,
                   5'd5, 5'd0, 32'hAA22CC44, 32'h0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 5'd7, 32'h12345678, 4'hF, 1'b1, 5'd7, 32'hFFFFFFFF, 4'h3, 1'b0, 5'd0,
                   5'd7, 5'd5, 32'h1234FFFF, 32'hAA22CC44, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd0, 32'hDEADBEEF, 4'hF, 1'b1, 5'd0, 32'hDEADBEEF, 4'hF, 1'b1, 5'd0,
                   5'd0, 5'd7, 32'h0, 32'h1234FFFF, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9,
                   5'd9, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 5'd9, 32'h00000099, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9,
                   5'd9, 5'd5, 32'h00000099, 32'hAA22CC44, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 32'h00000055, 4'h0, 1'b0, 5'd0,
                   5'd9, 5'd9, 32'h00000099, 32'h00000099, 1'b0, 1'b0};

        // Directed table: apply a cycle of writes/sets, then read back with inputs idle.
        for (int v = 0; v < 7; v++) begin
            wen0 = tbl[v].w0; waddr0 = tbl[v].a0; wdata0 = tbl[v].d0; wbe0 = tbl[v].be0;
            wen1 = tbl[v].w1; waddr1 = tbl[v].a1; wdata1 = tbl[v].d1; wbe1 = tbl[v].be1;
            set_en = tbl[v].se; set_addr = tbl[v].sa;
            tick();
            idle();
            raddr1 = tbl[v].ra1; raddr2 = tbl[v].ra2;
            #1;
            chk($sformatf("tbl%0d_rdata1", v), rdata1, tbl[v].e1);
            chk($sformatf("tbl%0d_rdata2", v), rdata2, tbl[v].e2);
            chk($sformatf("tbl%0d_busy1", v), 32'(busy1), 32'(tbl[v].eb1));
            chk($sformatf("tbl%0d_busy2", v), 32'(busy2), 32'(tbl[v].eb2));
        end

        // Same-cycle visibility: r3 write and r12 write (r12 pending) observed before the edge.
        set_en = 1'b1; set_addr = 5'd12;
        tick();
        idle();
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000CAFE; wbe0 = 4'hF;
        wen1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h00000012; wbe1 = 4'h1;
        raddr1 = 5'd3; raddr2 = 5'd12;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_rdata1", rdata1, 32'h0000CAFE);
        chk("byp_rdata2", rdata2, 32'h00000012);
        chk("byp_busy2", 32'(busy2), 32'h0);
`else
        chk("nobyp_rdata1", rdata1, 32'h0);
        chk("nobyp_rdata2", rdata2, 32'h0);
        chk("nobyp_busy2", 32'(busy2), 32'h1);
`endif
        tick();
        idle();
        #1;
        chk("post_rdata1", rdata1, 32'h0000CAFE);
        chk("post_rdata2", rdata2, 32'h00000012);
        chk("post_busy2", 32'(busy2), 32'h0);

        // Reset dominates a write and a set in the same cycle.
        rst = 1'b1;
        wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44444444; wbe0 = 4'hF;
        set_en = 1'b1; set_addr = 5'd4;
        tick();
        idle();
        raddr1 = 5'd4; raddr2 = 5'd5;
        #1;
        chk("rstprio_rdata1", rdata1, 32'h0);
        chk("rstprio_busy1", 32'(busy1), 32'h0);
        chk("rstprio_rdata2", rdata2, 32'h0);

        // Random traffic on a narrow address window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            wen0 = 1'($urandom); waddr0 = ADDR_W'($urandom_range(0, 7));
            wdata0 = $urandom; wbe0 = NB'($urandom);
            wen1 = 1'($urandom); waddr1 = ADDR_W'($urandom_range(0, 7));
            wdata1 = $urandom; wbe1 = NB'($urandom);
            set_en = ($urandom_range(0, 2) == 0); set_addr = ADDR_W'($urandom_range(0, 7));
            raddr1 = ADDR_W'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 1) == 0) ? waddr1 : ADDR_W'($urandom_range(0, 31));
            #1;
            chk("rnd_rdata1", rdata1, m_read(raddr1));
            chk("rnd_rdata2", rdata2, m_read(raddr2));
            chk("rnd_busy1", 32'(busy1), 32'(m_busy(raddr1)));
            chk("rnd_busy2", 32'(busy2), 32'(m_busy(raddr2)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
